// File: rtl/decode38_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode38_pkg
// Purpose  : Shared widths, FSM state encoding and one-hot decode helper.
// Revision : 1.0 - initial release
// ============================================================================
package decode38_pkg;

  localparam int ONEHOT_W = 8;
  localparam int CODE_W   = 3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  function automatic logic [ONEHOT_W-1:0] decode_onehot(input logic [CODE_W-1:0] idx);
    decode_onehot      = '0;
    decode_onehot[idx] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode38_hold_if.sv
`default_nettype none
// ============================================================================
// Module   : decode38_hold_if
// Purpose  : Code handshake and one-hot output bundle for decode38_hold.
// Revision : 1.0 - initial release
// ============================================================================
interface decode38_hold_if;
  import decode38_pkg::*;

  logic                en_in;
  logic                in_valid;
  logic                in_ready;
  logic [CODE_W-1:0]   code;
  logic [ONEHOT_W-1:0] y;
  logic                active;
  logic                done;

  modport master (
    output en_in,
    output in_valid,
    output code,
    input  in_ready,
    input  y,
    input  active,
    input  done
  );

  modport slave (
    input  en_in,
    input  in_valid,
    input  code,
    output in_ready,
    output y,
    output active,
    output done
  );

endinterface
`default_nettype wire

// File: rtl/decode38_hold_cnt.sv
`default_nettype none
// ============================================================================
// Module   : hold_cnt
// Purpose  : Load/decrement down-counter with zero flag; saturates at zero.
// Revision : 1.0 - initial release
// ============================================================================
module hold_cnt #(
  parameter int CNT_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             clr,
  input  wire logic             load,
  input  wire logic [CNT_W-1:0] load_val,
  input  wire logic             dec,
  output      logic             zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/decode38_hold.sv
`default_nettype none
// ============================================================================
// Module   : decode38_hold
// Purpose  : Registered 3-to-8 one-hot decoder holding each code for
//            HOLD_CYCLES cycles, paced by a valid/ready handshake.
//            Define DECODE38_QUEUE_EN for a one-entry code queue.
// Revision : 1.0 - initial release
// ============================================================================
module decode38_hold
  import decode38_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input wire logic       clk,
  input wire logic       rst_n,
  decode38_hold_if.slave bus
);

  localparam logic [CNT_W-1:0] c_reload = CNT_W'(HOLD_CYCLES - 1);

  state_t              r_state;
  state_t              w_nxt_state;
  logic [ONEHOT_W-1:0] r_y;
  logic [ONEHOT_W-1:0] w_nxt_y;
  logic                w_zero;
  logic                w_ready;
  logic                w_xfer;
  logic                w_cnt_clr;
  logic                w_cnt_load;
  logic                w_cnt_dec;

`ifdef DECODE38_QUEUE_EN
  logic                r_q_valid;
  logic                w_nxt_q_valid;
  logic [CODE_W-1:0]   r_q_code;
  logic [CODE_W-1:0]   w_nxt_q_code;

  assign w_ready = bus.en_in && !r_q_valid;
`else
  assign w_ready = bus.en_in && ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && w_zero));
`endif

  assign w_xfer = bus.in_valid && w_ready;

  hold_cnt #(
    .CNT_W (CNT_W)
  ) u_hold_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_cnt_clr),
    .load     (w_cnt_load),
    .load_val (c_reload),
    .dec      (w_cnt_dec),
    .zero     (w_zero)
  );

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_y       = r_y;
    w_cnt_clr     = 1'b0;
    w_cnt_load    = 1'b0;
    w_cnt_dec     = 1'b0;
`ifdef DECODE38_QUEUE_EN
    w_nxt_q_valid = r_q_valid;
    w_nxt_q_code  = r_q_code;
`endif
    if (!bus.en_in) begin
      // Abort whatever is in flight; no completion pulse is produced.
      w_nxt_state   = ST_IDLE;
      w_nxt_y       = '0;
      w_cnt_clr     = 1'b1;
`ifdef DECODE38_QUEUE_EN
      w_nxt_q_valid = 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            w_nxt_y     = decode_onehot(bus.code);
            w_cnt_load  = 1'b1;
            w_nxt_state = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!w_zero) begin
            w_cnt_dec = 1'b1;
`ifdef DECODE38_QUEUE_EN
            if (w_xfer) begin
              w_nxt_q_valid = 1'b1;
              w_nxt_q_code  = bus.code;
            end
`endif
          end else begin
`ifdef DECODE38_QUEUE_EN
            // Queued code wins over a direct input on the last hold cycle.
            if (r_q_valid) begin
              w_nxt_y       = decode_onehot(r_q_code);
              w_cnt_load    = 1'b1;
              w_nxt_q_valid = w_xfer;
              if (w_xfer) begin
                w_nxt_q_code = bus.code;
              end
            end else
`endif
            if (w_xfer) begin
              w_nxt_y    = decode_onehot(bus.code);
              w_cnt_load = 1'b1;
            end else begin
              w_nxt_y     = '0;
              w_nxt_state = ST_IDLE;
            end
          end
        end
        default: begin
          w_nxt_y     = '0;
          w_cnt_clr   = 1'b1;
          w_nxt_state = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_y       <= '0;
`ifdef DECODE38_QUEUE_EN
      r_q_valid <= 1'b0;
      r_q_code  <= '0;
`endif
    end else begin
      r_state   <= w_nxt_state;
      r_y       <= w_nxt_y;
`ifdef DECODE38_QUEUE_EN
      r_q_valid <= w_nxt_q_valid;
      r_q_code  <= w_nxt_q_code;
`endif
    end
  end

  assign bus.y        = r_y;
  assign bus.active   = (r_state == ST_HOLD);
  assign bus.done     = bus.en_in && (r_state == ST_HOLD) && w_zero;
  assign bus.in_ready = w_ready;

endmodule
`default_nettype wire

// File: tb/tb_decode38_hold.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode38_hold
// Purpose  : Bench for decode38_hold, HOLD_CYCLES=4 and HOLD_CYCLES=1 side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode38_hold;

`ifdef DECODE38_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       valid;
  logic [2:0] code;

  always #5 clk = ~clk;

  decode38_hold_if bus4();
  decode38_hold_if bus1();

  assign bus4.en_in    = en;
  assign bus4.in_valid = valid;
  assign bus4.code     = code;
  assign bus1.en_in    = en;
  assign bus1.in_valid = valid;
  assign bus1.code     = code;

  decode38_hold #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  decode38_hold #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  // Reference: cycles of hold left for the current line (0 = idle) plus a pending slot.
  int hold_len [2] = '{4, 1};
  int m_left   [2] = '{0, 0};
  int m_line   [2] = '{0, 0};
  bit m_qv     [2] = '{1'b0, 1'b0};
  int m_qc     [2] = '{0, 0};

  int n_vec = 0;
  int n_err = 0;
  bit acc0;

  function automatic bit exp_ready(input int d);
    if (!en) return 1'b0;
    if (QUEUE) return !m_qv[d];
    return (m_left[d] <= 1);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int d, input logic [7:0] y, input logic act,
                           input logic dn, input logic rdy);
    logic [7:0] ey;
    ey = (m_left[d] > 0) ? (8'h01 << m_line[d]) : 8'h00;
    check($sformatf("h%0d.y", hold_len[d]), y, ey);
    check($sformatf("h%0d.active", hold_len[d]), {7'b0, act}, {7'b0, (m_left[d] > 0)});
    check($sformatf("h%0d.done", hold_len[d]), {7'b0, dn}, {7'b0, (en && m_left[d] == 1)});
    check($sformatf("h%0d.in_ready", hold_len[d]), {7'b0, rdy}, {7'b0, exp_ready(d)});
  endtask

  task automatic model_edge(input int d);
    bit xfer;
    xfer = valid && exp_ready(d);
    if (!rst_n || !en) begin
      m_left[d] = 0;
      m_qv[d]   = 1'b0;
    end else if (m_left[d] == 0) begin
      if (xfer) begin
        m_line[d] = int'(code);
        m_left[d] = hold_len[d];
      end
    end else if (m_left[d] > 1) begin
      m_left[d]--;
      if (xfer) begin
        m_qv[d] = 1'b1;
        m_qc[d] = int'(code);
      end
    end else if (m_qv[d]) begin
      m_line[d] = m_qc[d];
      m_left[d] = hold_len[d];
      m_qv[d]   = xfer;
      if (xfer) m_qc[d] = int'(code);
    end else if (xfer) begin
      m_line[d] = int'(code);
      m_left[d] = hold_len[d];
    end else begin
      m_left[d] = 0;
    end
  endtask

  // Drive one cycle's inputs, check both DUTs before the edge, then advance the model.
  task automatic step(input logic r, input logic e, input logic v,
                      input logic [2:0] c, input bit chk);
    rst_n = r;
    en    = e;
    valid = v;
    code  = c;
    #1;
    if (chk) begin
      check_dut(0, bus4.y, bus4.active, bus4.done, bus4.in_ready);
      check_dut(1, bus1.y, bus1.active, bus1.done, bus1.in_ready);
    end
    acc0 = r && v && exp_ready(0);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
  endtask

  initial begin
    int idx;
    int guard;
    rst_n = 1'b0;
    en    = 1'b0;
    valid = 1'b0;
    code  = 3'd0;
    @(negedge clk);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 3'd0, 1'b1);

    // Single code 5, then drain.
    step(1'b1, 1'b1, 1'b1, 3'd5, 1'b1);
    repeat (6) step(1'b1, 1'b1, 1'b0, 3'd0, 1'b1);

    // Back-to-back 0,1,2 with valid held high.
    idx   = 0;
    guard = 0;
    while (idx < 3 && guard < 40) begin
      step(1'b1, 1'b1, 1'b1, 3'(idx), 1'b1);
      if (acc0) idx++;
      guard++;
    end
    repeat (5) step(1'b1, 1'b1, 1'b0, 3'd0, 1'b1);

    // Enable dropped in the second hold cycle of code 7.
    step(1'b1, 1'b1, 1'b1, 3'd7, 1'b1);
    step(1'b1, 1'b1, 1'b0, 3'd7, 1'b1);
    step(1'b1, 1'b0, 1'b1, 3'd7, 1'b1);
    step(1'b1, 1'b0, 1'b1, 3'd7, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0, 3'd0, 1'b1);

    // Reset on the last hold cycle together with a transfer.
    step(1'b1, 1'b1, 1'b1, 3'd2, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 3'd4, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0, 3'd0, 1'b1);

    // Code 6 then code 3 offered from the first hold cycle.
    step(1'b1, 1'b1, 1'b1, 3'd6, 1'b1);
    guard = 0;
    acc0  = 1'b0;
    while (!acc0 && guard < 10) begin
      step(1'b1, 1'b1, 1'b1, 3'd3, 1'b1);
      guard++;
    end
    repeat (10) step(1'b1, 1'b1, 1'b0, 3'd0, 1'b1);

    // Continuous stream walking codes 0..7 twice.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b1, 3'(i), 1'b1);
    repeat (6) step(1'b1, 1'b1, 1'b0, 3'd0, 1'b1);

    // Random traffic with occasional reset and enable drops.
    repeat (400) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 15) != 0),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b1);
    end
    repeat (6) step(1'b1, 1'b1, 1'b0, 3'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
